// File: rtl/dbus_uncached_bridge_pkg.sv
// ---------------------------------------------------------------------------
// dbus_uncached_bridge_pkg
//   Shared bus types for the CPU data bus (dbus) and the cache bus (cbus),
//   plus the uncached bridge FSM state type and an alignment helper that the
//   cache and LSU can reuse.
//
//   Types:
//     addr_t, msize_t, strobe_t, word_t       - basic field types
//     mlen_t, axi_burst_t                     - cbus burst descriptors
//     dbus_req_t / dbus_resp_t                - CPU side request/response
//     cbus_req_t / cbus_resp_t                - memory side request/response
//     bridge_state_t                          - IDLE / BUSY / DONE
//   Functions:
//     misaligned(addr, size)                  - 1 when addr is not a multiple
//                                               of (1 << size)
// ---------------------------------------------------------------------------
package dbus_uncached_bridge_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [7:0]  strobe_t;
   typedef logic [63:0] word_t;

   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   // AXI-style length encoding: number of beats minus one.
   typedef enum logic [3:0] {
      MLEN1  = 4'd0,
      MLEN2  = 4'd1,
      MLEN4  = 4'd3,
      MLEN8  = 4'd7,
      MLEN16 = 4'd15
   } mlen_t;

   typedef enum logic [1:0] {
      AXI_BURST_FIXED = 2'b00,
      AXI_BURST_INCR  = 2'b01,
      AXI_BURST_WRAP  = 2'b10
   } axi_burst_t;

   typedef struct packed {
      logic    valid;
      addr_t   addr;
      msize_t  size;
      strobe_t strobe;
      word_t   data;
   } dbus_req_t;

   typedef struct packed {
      logic  addr_ok;
      logic  data_ok;
      word_t data;
   } dbus_resp_t;

   typedef struct packed {
      logic       valid;
      logic       is_write;
      msize_t     size;
      addr_t      addr;
      strobe_t    strobe;
      word_t      data;
      mlen_t      len;
      axi_burst_t burst;
   } cbus_req_t;

   typedef struct packed {
      logic  ready;
      logic  last;
      word_t data;
   } cbus_resp_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } bridge_state_t;

   // An access of 2**size bytes is aligned when the low size bits are zero.
   function automatic logic misaligned(input addr_t addr, input msize_t size);
      addr_t mask;
      mask = (addr_t'(32'd1) << size) - addr_t'(32'd1);
      return |(addr & mask);
   endfunction

endpackage

// File: rtl/dbus_uncached_bridge.sv
// ---------------------------------------------------------------------------
// dbus_uncached_bridge
//   Converts one CPU data-bus request into one single-beat cache-bus
//   transaction for uncached (MMIO) regions. One request is outstanding at a
//   time; a watchdog aborts requests to slaves that never answer.
//
//   Parameters:
//     TIMEOUT_CYCLES - BUSY cycles before abort (0 disables the watchdog)
//     CNT_W          - watchdog counter width (TIMEOUT_CYCLES < 2**CNT_W)
//
//   Ports:
//     clk     in   system clock
//     resetn  in   asynchronous active-low reset
//     dreq    in   request from CPU
//     dresp   out  response to CPU (addr_ok combinational in IDLE)
//     creq    out  request to cache bus (driven only in BUSY)
//     cresp   in   response from cache bus
//     bus_err out  pulse with data_ok when the request was aborted
//
//   Optional feature macro: DBUS_BRIDGE_ALIGN_CHECK_EN
//     When defined, a misaligned request skips the cbus and completes in DONE
//     with data 0 and bus_err set.
// ---------------------------------------------------------------------------
module dbus_uncached_bridge
   import dbus_uncached_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic       clk,
   input  logic       resetn,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp,
   output cbus_req_t  creq,
   input  cbus_resp_t cresp,
   output logic       bus_err
);

   localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

   bridge_state_t    state_q,  state_d;
   addr_t            addr_q,   addr_d;
   msize_t           size_q,   size_d;
   strobe_t          strobe_q, strobe_d;
   word_t            wdata_q,  wdata_d;
   word_t            rdata_q,  rdata_d;
   logic             err_q,    err_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;

   logic beat_done_s;
   logic timeout_hit_s;
   logic misaligned_s;

   assign beat_done_s   = cresp.ready & cresp.last;
   // The counter equals the BUSY cycle index, so the abort happens at the end
   // of BUSY cycle number TIMEOUT_CYCLES.
   assign timeout_hit_s = TIMEOUT_EN & (cnt_q == CNT_LAST);

`ifdef DBUS_BRIDGE_ALIGN_CHECK_EN
   assign misaligned_s = misaligned(dreq.addr, dreq.size);
`else
   assign misaligned_s = 1'b0;
`endif

   // Next-state and latch logic for the request FSM.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      size_d   = size_q;
      strobe_d = strobe_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (dreq.valid) begin
               addr_d   = dreq.addr;
               size_d   = dreq.size;
               strobe_d = dreq.strobe;
               wdata_d  = dreq.data;
               rdata_d  = 64'd0;
               cnt_d    = '0;
               if (misaligned_s) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  err_d   = 1'b0;
                  state_d = BUSY;
               end
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            // A completing beat takes priority over a watchdog hit on the
            // same edge.
            if (beat_done_s) begin
               rdata_d = (|strobe_q) ? 64'd0 : cresp.data;
               state_d = DONE;
            end else if (timeout_hit_s) begin
               rdata_d = 64'd0;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               state_d = BUSY;
            end
         end
         DONE: begin
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: begin
            err_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and latched request fields.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         addr_q   <= 32'd0;
         size_q   <= MSIZE1;
         strobe_q <= 8'd0;
         wdata_q  <= 64'd0;
         rdata_q  <= 64'd0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         strobe_q <= strobe_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   // Output decode: creq only from registers in BUSY, data_ok only in DONE.
   always_comb begin
      creq    = '0;
      dresp   = '0;
      bus_err = 1'b0;
      case (state_q)
         IDLE: begin
            // Gated by resetn so the CPU never sees an accept while in reset.
            dresp.addr_ok = dreq.valid & resetn;
         end
         BUSY: begin
            creq.valid    = 1'b1;
            creq.is_write = |strobe_q;
            creq.size     = size_q;
            creq.addr     = addr_q;
            creq.strobe   = strobe_q;
            creq.data     = wdata_q;
            creq.len      = MLEN1;
            creq.burst    = AXI_BURST_FIXED;
         end
         DONE: begin
            dresp.data_ok = 1'b1;
            dresp.data    = rdata_q;
            bus_err       = err_q;
         end
         default: begin
            bus_err = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/dbus_uncached_bridge.md
Name: dbus_uncached_bridge

Overview:
- Converts one data-bus request (dbus_req_t/dbus_resp_t, CPU side) into one single-beat cache-bus transaction (cbus_req_t/cbus_resp_t, memory side).
- Sits directly downstream of the memory stage for uncached (MMIO) regions, in parallel with the data cache.
- Upstream it feeds the cbus arbiter/AXI adapter.
- Handles one outstanding request at a time and has a watchdog for hung slaves.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles spent in BUSY before the request is aborted; 0 disables the watchdog.
- CNT_W, 16: watchdog counter width; requires TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- dreq  in  dbus_req_t  request from CPU
- dresp  out  dbus_resp_t  response to CPU
- creq  out  cbus_req_t  request to cache bus
- cresp  in  cbus_resp_t  response from cache bus
- bus_err  out  1  one-cycle pulse, coincident with data_ok, when the request was aborted by the watchdog (or misaligned, see optional feature)

Behaviour:
- Reset: asynchronous, active-low. While resetn is low:
  - state = IDLE; all latched fields and the watchdog counter = 0.
  - creq = all-zero (valid=0); dresp.addr_ok = 0, dresp.data_ok = 0, dresp.data = 0; bus_err = 0.
- Reset asserted mid-transaction: creq.valid drops immediately with no completion to the CPU. A slave beat arriving afterwards is ignored.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - dresp.addr_ok = dreq.valid, combinationally.
  - On a clock edge with dreq.valid=1: latch addr, size, strobe and data; clear the counter; go to BUSY.
- BUSY:
  - creq is driven from registers and held stable for the whole state.
  - creq.valid=1; creq.is_write = |strobe; creq.len = MLEN1; creq.burst = AXI_BURST_FIXED.
  - creq.addr, size, strobe and data come from the latched values.
  - Edge with cresp.ready && cresp.last: latch cresp.data (reads only; writes latch 0); go to DONE.
  - cresp.ready without last: ignored, stay in BUSY.
  - Counter increments each cycle in BUSY. If TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1 with no completing beat: latch data = 0, set the err flag, go to DONE.
  - If completion and timeout fall on the same edge, completion wins and err stays clear.
- DONE:
  - dresp.data_ok = 1 and dresp.data = latched data for exactly one cycle; bus_err = err flag.
  - Next state is IDLE; the err flag is cleared.
- addr_ok is 0 outside IDLE. dreq changes after acceptance are ignored.
- Back-to-back requests: a new request can be accepted in the cycle after DONE.
- Minimum latency, accept to data_ok: 3 cycles when cresp answers in the first BUSY cycle.
- Data/strobe placement: passed through unmodified. The CPU supplies lane-aligned data and strobe per the dbus convention; the bridge never shifts lanes.

Optional Feature:
- Macro: DBUS_BRIDGE_ALIGN_CHECK_EN.
- Defined: in IDLE, an accepted request whose addr is not a multiple of (1 << size) goes straight to DONE.
  - No cbus transaction is issued.
  - Response is data = 0 and bus_err = 1 with data_ok.
  - Minimum latency for this case is 2 cycles.
- Undefined: no check; every accepted request is issued on cbus.

Decomposition:
- Shared package (common), added there:
  - bridge_state_t enum {IDLE, BUSY, DONE}.
  - A function misaligned(addr_t, msize_t) returning logic, for reuse by the cache and LSU.
- No sub-module: FSM, latches and counter stay in one module, well under 250 lines.

Test Plan:
- Read: dreq {valid, addr 0x1000_0008, MSIZE4, strobe 0}; slave answers ready+last with 0x0000_0000_DEAD_BEEF after 2 cycles -> addr_ok one cycle; creq held with is_write=0, len MLEN1; data_ok with data 0x...DEADBEEF; bus_err=0.
- Write: addr 0x1000_0004, MSIZE4, strobe 8'hF0, data 0x1234_5678_0000_0000 -> creq.is_write=1, strobe/data passed unchanged; data_ok with data 0.
- Timeout: TIMEOUT_CYCLES=8, slave never ready -> exactly 8 BUSY cycles, then data_ok with bus_err=1, data 0; a following request completes normally.
- Reset mid-BUSY: deassert resetn on BUSY cycle 2 -> creq.valid=0 immediately; no data_ok; after resetn=1, next request works.
- Back-to-back: dreq.valid held high across two requests -> second addr_ok in the cycle after the first data_ok; both responses in order with correct data.
- With DBUS_BRIDGE_ALIGN_CHECK_EN: addr 0x1000_0002, MSIZE4 -> no creq.valid; data_ok plus bus_err 2 cycles after acceptance.
